// File: rtl/demux4_frame.sv
// Purpose: 1-to-4 demux that assembles four lane writes into one frame for a valid/ready consumer.
// Latency: out_valid rises 1 cycle after the accept that completes the fourth distinct lane.
// Backpressure: in_ready drops while a frame is held; one bubble cycle after the frame handshake.
// Optional: define DEMUX4_PARITY_EN to add the registered frame parity output par.
module demux4_frame #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   din,
    input  logic [1:0]         a,
    input  logic               auto,
    output logic [4*WIDTH-1:0] d,
    output logic [3:0]         lane_wr,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef DEMUX4_PARITY_EN
    output logic               par,
`endif
    output logic [1:0]         ptr
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic [1:0]         tgt;
    logic [4*WIDTH-1:0] d_nxt;
    logic [3:0]         lane_wr_nxt;
    logic [1:0]         ptr_nxt;
    logic               out_valid_nxt;

    // Next-state and next-register values; in_ready comes from state alone.
    always_comb begin
        state_nxt     = state;
        d_nxt         = d;
        lane_wr_nxt   = lane_wr;
        ptr_nxt       = ptr;
        out_valid_nxt = out_valid;
        in_ready      = (state == FILL);
        accept        = in_valid & (state == FILL);
        tgt           = auto ? ptr : a;
        case (state)
            FILL: begin
                if (accept) begin
                    d_nxt[int'(tgt)*WIDTH +: WIDTH] = din;
                    lane_wr_nxt[tgt]                = 1'b1;
                    if (auto) begin
                        ptr_nxt = ptr + 2'd1;
                    end
                    if (&lane_wr_nxt) begin
                        state_nxt     = FULL;
                        out_valid_nxt = 1'b1;
                    end
                end
            end
            FULL: begin
                // Frame is taken: clear write flags but leave lane data in place.
                if (out_ready) begin
                    lane_wr_nxt   = '0;
                    out_valid_nxt = 1'b0;
                    state_nxt     = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            d         <= '0;
            lane_wr   <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            d         <= d_nxt;
            lane_wr   <= lane_wr_nxt;
            ptr       <= ptr_nxt;
            out_valid <= out_valid_nxt;
        end
    end

`ifdef DEMUX4_PARITY_EN
    // Parity of the completed frame, captured on the edge that fills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (state == FILL && state_nxt == FULL) begin
            par <= ^d_nxt;
        end
    end
`endif

endmodule
